time_display_scan: RTL
======================

# time_display_scan

Multiplexed seven-segment driver for the clock display on the Artix-7 board. It is the consumer of the six per-digit time values produced by the clock/time-entry logic (hrs tens/ones, min tens/ones, sec tens/ones). It time-multiplexes those values onto six of the board's eight common-anode digits. It also blinks the field currently being edited.

## Interface
Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz).
- GUARD, 16: cycles at the start of each slot during which all anodes are off (anti-ghosting). Requires GUARD < SCAN_DIV.
- BLINK_DIV, 25000000: clock cycles per blink half-period (2 Hz blink at 100 MHz).

Ports:
- clk, in, 1: system clock. Single clock domain.
- reset, in, 1: synchronous, active-high reset.
- hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones, in, 6 each: digit values, legal range 0–9.
- mode, in, 3: edit mode. 1 = seconds, 2 = minutes, 3 = hours, any other value = none.
- an, out, 8: anode enables, active-low. an[0] is the rightmost digit.
- seg, out, 7: {g,f,e,d,c,b,a}, active-low.
- dp, out, 1: decimal point, active-low.

## Operation
- Slot counter scan_cnt counts 0..SCAN_DIV-1 and wraps. On wrap, the digit index idx advances 0→1→…→5→0.
- idx mapping:
  - 0 = sec_ones, 1 = sec_tens, 2 = min_ones, 3 = min_tens, 4 = hrs_ones, 5 = hrs_tens.
  - Digit idx drives an[idx]. an[7:6] are always 1.
- Segment decode:
  - Values 0–9 use the standard patterns, e.g. 0 = 7'b1000000, 8 = 7'b0000000.
  - Values 10–63 display a dash, 7'b0111111, as an illegal-value indicator.
- dp = 0 (lit) when idx is 2 or 4, giving HH.MM.SS separators. Otherwise dp = 1.
- Guard: while scan_cnt < GUARD, an = 8'hFF. seg and dp still track the current idx.
- Blink:
  - Blink counter counts 0..BLINK_DIV-1. On each wrap it toggles the phase bit.
  - When phase = 1, the anodes of the edited pair are forced off: mode 1 → idx 0,1; mode 2 → idx 2,3; mode 3 → idx 4,5.
  - Mode 0 or modes 4–7 blink nothing.
  - A mode change takes effect on the next registered update. It does not reset the blink counter.
- The inputs are not latched per slot. A value change mid-slot appears on seg one cycle later.

## Timing
- an, seg and dp are registered. Each output cycle N+1 reflects idx, scan_cnt, phase, mode and digit inputs as sampled at edge N.
- Reset values:
  - an = 8'hFF, seg = 7'h7F, dp = 1.
  - scan_cnt = 0, idx = 0, blink counter = 0, phase = 0 (visible).
- After reset deasserts:
  - Cycles 1..GUARD: an = 8'hFF.
  - Cycle GUARD+1: an = 8'hFE.
- idx advances on the edge where scan_cnt = SCAN_DIV-1. The new digit's guard window begins on the next output.
- Wrap 5→0 has no extra dead cycle.
- Reset asserted mid-slot or mid-blink: all state returns to reset values on that edge, and outputs are blank the following cycle.
- Slot wrap coinciding with blink toggle: both take effect on the same edge. Neither is delayed.

## Configuration
- TIME_DISPLAY_BLINK_EN defined: the blink counter, phase and edit-pair masking are present as described.
- TIME_DISPLAY_BLINK_EN undefined:
  - The blink logic is not built and the mode port is ignored.
  - No digit is ever blanked except by the guard window.
  - All other timing is identical.

## Structure
- Package time_display_pkg holds:
  - Segment pattern constants SEG_0..SEG_9, SEG_DASH and SEG_BLANK.
  - Mode constants MODE_NONE = 0, MODE_SEC = 1, MODE_MIN = 2, MODE_HRS = 3.
  - The digit-index typedef, 3 bits.
- Sub-module seg7_decode: combinational 6-bit value to 7-bit active-low pattern, including the dash for values above 9. It is instantiated once, fed by the idx-selected digit.

## Test plan
Bench parameters: SCAN_DIV = 8, GUARD = 2, BLINK_DIV = 64.
- Reset, then digits 1,2,3,4,5,6 (hrs_tens..sec_ones) with mode 0 → the an sequence over 48 cycles is FF,FF,FE×6, FF,FF,FD×6, … through DF. seg shows 6,5,4,3,2,1 in turn. dp = 0 only during the an=FB and an=EF slots.
- sec_ones = 12 → the slot for an=FE shows seg = 7'b0111111.
- mode = 2 with BLINK_EN defined → during phase = 1 (cycles 65–128), an never equals FB or F7. During phase = 0, both appear. With the macro undefined, both appear in every frame.
- Reset asserted at scan_cnt = 5 of idx 3 → the next cycle gives an = FF, seg = 7F, dp = 1. After release, GUARD blank cycles are followed by an = FE.
- Change min_ones from 4 to 7 mid-slot while an = FB → seg switches from the 4 pattern to the 7 pattern exactly one cycle after the input change, and an is unchanged.

Source files
------------

// File: rtl/time_display_pkg.sv
// rtl/time_display_pkg.sv - segment patterns, edit modes and digit index type for the time display
package time_display_pkg;

  // Patterns are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] MODE_NONE = 3'd0;
  localparam logic [2:0] MODE_SEC  = 3'd1;
  localparam logic [2:0] MODE_MIN  = 3'd2;
  localparam logic [2:0] MODE_HRS  = 3'd3;

  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t LAST_IDX = 3'd5;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 6-bit digit value to active-low seven-segment pattern, dash above 9
module seg7_decode
  import time_display_pkg::*;
(
  input  logic [5:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (value)
      6'd0: seg = SEG_0;
      6'd1: seg = SEG_1;
      6'd2: seg = SEG_2;
      6'd3: seg = SEG_3;
      6'd4: seg = SEG_4;
      6'd5: seg = SEG_5;
      6'd6: seg = SEG_6;
      6'd7: seg = SEG_7;
      6'd8: seg = SEG_8;
      6'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/time_display_scan.sv
// rtl/time_display_scan.sv - six-digit multiplexed seven-segment scanner with guard window
// and edited-field blink (blink built only when TIME_DISPLAY_BLINK_EN is defined)
module time_display_scan
  import time_display_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] hrs_tens,
  input  logic [5:0] hrs_ones,
  input  logic [5:0] min_tens,
  input  logic [5:0] min_ones,
  input  logic [5:0] sec_tens,
  input  logic [5:0] sec_ones,
  input  logic [2:0] mode,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] scan_cnt;
  digit_idx_t    idx;
  logic          scan_wrap;
  logic          in_guard;
  logic          edit_blank;
  logic [5:0]    digit;
  logic [6:0]    seg_next;
  logic [7:0]    an_next;
  logic          dp_next;

  assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));
  assign in_guard  = (scan_cnt < SW'(GUARD));

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= (idx == LAST_IDX) ? digit_idx_t'(0) : digit_idx_t'(idx + 3'd1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

`ifdef TIME_DISPLAY_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt;
  logic          phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // The edited pair is idx {0,1}, {2,3} or {4,5}; idx[2:1] names the pair.
  always_comb begin
    edit_blank = 1'b0;
    if (phase) begin
      case (mode)
        MODE_SEC: edit_blank = (idx[2:1] == 2'd0);
        MODE_MIN: edit_blank = (idx[2:1] == 2'd1);
        MODE_HRS: edit_blank = (idx[2:1] == 2'd2);
        default:  edit_blank = 1'b0;
      endcase
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^mode;
  assign edit_blank  = 1'b0;
`endif

  always_comb begin
    digit = sec_ones;
    case (idx)
      3'd0:    digit = sec_ones;
      3'd1:    digit = sec_tens;
      3'd2:    digit = min_ones;
      3'd3:    digit = min_tens;
      3'd4:    digit = hrs_ones;
      3'd5:    digit = hrs_tens;
      default: digit = sec_ones;
    endcase
  end

  seg7_decode u_decode (
    .value (digit),
    .seg   (seg_next)
  );

  always_comb begin
    an_next = 8'hFF;
    if (!in_guard && !edit_blank) begin
      an_next[idx] = 1'b0;
    end
    dp_next = !((idx == 3'd2) || (idx == 3'd4));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule
